// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage RISC-V pipeline: widths, result-source
// encodings and the memory-stage FSM state type.
package pipe_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with writeback result select; a bubble retires the
// slot with its register write suppressed.
module mem_wb_reg
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_bubble,
   input  logic              i_regWrite,
   input  logic [REG_AW-1:0] i_rd,
   input  logic              i_lui,
   input  logic [1:0]        i_resultSrc,
   input  logic [XLEN-1:0]   i_aluResult,
   input  logic [XLEN-1:0]   i_pcPlus4,
   input  logic [XLEN-1:0]   i_extImm,
   input  logic [XLEN-1:0]   i_memRData,
   output logic              o_regWrite,
   output logic [REG_AW-1:0] o_rd,
   output logic [XLEN-1:0]   o_result
);
   logic [XLEN-1:0] w_result;

   // LUI overrides the encoded source; the unused encoding 11 falls back to ALU
   always_comb begin
      w_result = i_aluResult;
      if (i_lui) begin
         w_result = i_extImm;
      end else begin
         case (i_resultSrc)
            RES_ALU: w_result = i_aluResult;
            RES_MEM: w_result = i_memRData;
            RES_PC4: w_result = i_pcPlus4;
            default: w_result = i_aluResult;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_regWrite <= 1'b0;
         o_rd       <= '0;
         o_result   <= '0;
      end else begin
         o_regWrite <= i_regWrite & ~i_bubble;
         o_rd       <= i_rd;
         o_result   <= w_result;
      end
   end
endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues word loads/stores over a req/ready port, stalls the
// upstream pipeline while an access is outstanding, and feeds MEM/WB.
module mem_access_stage
   import pipe_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memWriteM,
   input  logic              regWriteM,
   input  logic              luiM,
   input  logic [1:0]        resultSrcM,
   input  logic [REG_AW-1:0] RdM,
   input  logic [XLEN-1:0]   ALUResultM,
   input  logic [XLEN-1:0]   writeDataM,
   input  logic [XLEN-1:0]   PCPlus4M,
   input  logic [XLEN-1:0]   extImmM,
   output logic              memReq,
   output logic              memWe,
   output logic [XLEN-1:0]   memAddr,
   output logic [XLEN-1:0]   memWData,
   input  logic              memReady,
   input  logic [XLEN-1:0]   memRData,
   output logic              stallM,
   output logic              regWriteW,
   output logic [REG_AW-1:0] RdW,
   output logic [XLEN-1:0]   resultW,
   output logic              memErr
);
   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_memReq;
   logic              r_memWe;
   logic [XLEN-1:0]   r_memAddr;
   logic [XLEN-1:0]   r_memWData;
   logic              r_memErr;

   logic w_access;
   logic w_misaligned;
   logic w_stall;
   logic w_done;
   logic w_timeout;
   logic w_bubble;

   assign w_access     = memWriteM | ((resultSrcM == RES_MEM) & ~luiM);
   assign w_misaligned = w_access & (ALUResultM[1:0] != 2'b00);

   // A timeout on the last BUSY cycle completes like a ready, but as an abort
   always_comb begin
      w_next    = r_state;
      w_stall   = 1'b0;
      w_done    = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_access && !w_misaligned) begin
               w_stall = 1'b1;
               w_next  = BUSY;
            end
         end
         BUSY: begin
            w_timeout = !memReady && (r_cnt == CNT_LAST);
            if (memReady || w_timeout) begin
               w_done = 1'b1;
               w_next = IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_bubble = w_stall | ((r_state == IDLE) & w_misaligned) | w_timeout
                   | (w_done & memWriteM);
   assign stallM   = w_stall & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_memReq   <= 1'b0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWData <= '0;
         r_memErr   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_stall) begin
            r_memReq   <= 1'b1;
            r_memWe    <= memWriteM;
            r_memAddr  <= ALUResultM;
            r_memWData <= writeDataM;
            r_cnt      <= '0;
         end else if (w_done) begin
            r_memReq <= 1'b0;
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (((r_state == IDLE) && w_misaligned) || w_timeout) begin
            r_memErr <= 1'b1;
         end
      end
   end

   assign memReq   = r_memReq;
   assign memWe    = r_memWe;
   assign memAddr  = r_memAddr;
   assign memWData = r_memWData;
   assign memErr   = r_memErr;

   mem_wb_reg u_mem_wb_reg (
      .clk         (clk),
      .rst         (rst),
      .i_bubble    (w_bubble),
      .i_regWrite  (regWriteM),
      .i_rd        (RdM),
      .i_lui       (luiM),
      .i_resultSrc (resultSrcM),
      .i_aluResult (ALUResultM),
      .i_pcPlus4   (PCPlus4M),
      .i_extImm    (extImmM),
      .i_memRData  (memRData),
      .o_regWrite  (regWriteW),
      .o_rd        (RdW),
      .o_result    (resultW)
   );
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: instructions are driven one at a time,
// the expected MEM/WB contents queued and compared when the instruction retires.
module tb_mem_access_stage;
   localparam int TO = 16;

   logic        clk;
   logic        rst;
   logic        memWriteM;
   logic        regWriteM;
   logic        luiM;
   logic [1:0]  resultSrcM;
   logic [4:0]  RdM;
   logic [31:0] ALUResultM;
   logic [31:0] writeDataM;
   logic [31:0] PCPlus4M;
   logic [31:0] extImmM;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWData;
   logic        memReady;
   logic [31:0] memRData;
   logic        stallM;
   logic        regWriteW;
   logic [4:0]  RdW;
   logic [31:0] resultW;
   logic        memErr;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] res;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   int          stalls;
   int          busy;
   logic        addr_ok;
   logic        saw_req;
   logic        last_we;
   logic [31:0] last_wd;

   mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .memWriteM  (memWriteM),
      .regWriteM  (regWriteM),
      .luiM       (luiM),
      .resultSrcM (resultSrcM),
      .RdM        (RdM),
      .ALUResultM (ALUResultM),
      .writeDataM (writeDataM),
      .PCPlus4M   (PCPlus4M),
      .extImmM    (extImmM),
      .memReq     (memReq),
      .memWe      (memWe),
      .memAddr    (memAddr),
      .memWData   (memWData),
      .memReady   (memReady),
      .memRData   (memRData),
      .stallM     (stallM),
      .regWriteW  (regWriteW),
      .RdW        (RdW),
      .resultW    (resultW),
      .memErr     (memErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_instr(input logic mw, input logic rw, input logic lui,
                            input logic [1:0] src, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] wd,
                            input logic [31:0] pc4, input logic [31:0] imm);
      memWriteM  = mw;
      regWriteM  = rw;
      luiM       = lui;
      resultSrcM = src;
      RdM        = rd;
      ALUResultM = alu;
      writeDataM = wd;
      PCPlus4M   = pc4;
      extImmM    = imm;
   endtask

   task automatic push_exp(input logic we, input logic [4:0] rd, input logic [31:0] res);
      exp_t e;
      e.we  = we;
      e.rd  = rd;
      e.res = res;
      sb.push_back(e);
   endtask

   // Memory model: ready raised on BUSY cycle index ready_at (-1 = never).
   task automatic run_instr(input int ready_at, input logic [31:0] rdata);
      int guard;
      stalls  = 0;
      busy    = 0;
      addr_ok = 1'b1;
      saw_req = 1'b0;
      last_we = 1'b0;
      last_wd = '0;
      guard   = 0;
      memRData = rdata;
      forever begin
         memReady = memReq && (busy == ready_at);
         #1;
         if (memReq) begin
            saw_req = 1'b1;
            if (memAddr !== ALUResultM) addr_ok = 1'b0;
            last_we = memWe;
            last_wd = memWData;
            busy++;
         end
         if (!stallM) break;
         stalls++;
         guard++;
         if (guard > 200) begin
            total++;
            bad++;
            $error("FAIL stall_bound observed=%0d expected<=200", guard);
            break;
         end
         tick();
      end
      tick();
      memReady = 1'b0;
      #1;
   endtask

   task automatic check_wb(input string tag);
      exp_t e;
      e = sb.pop_front();
      chk({tag, "_regWriteW"}, 32'(regWriteW), 32'(e.we));
      if (e.we) begin
         chk({tag, "_RdW"}, 32'(RdW), 32'(e.rd));
         chk({tag, "_resultW"}, resultW, e.res);
      end
   endtask

   initial begin
      rst = 1'b1;
      memReady = 1'b0;
      memRData = '0;
      // aligned load presented during reset: stall must stay forced low
      set_instr(0, 1, 0, 2'b01, 5'd2, 32'h0000_0100, 0, 0, 0);
      tick();
      tick();
      chk("rst_stallM", 32'(stallM), 0);
      chk("rst_memReq", 32'(memReq), 0);
      chk("rst_memErr", 32'(memErr), 0);
      chk("rst_regWriteW", 32'(regWriteW), 0);
      chk("rst_resultW", resultW, 0);
      chk("rst_memAddr", memAddr, 0);
      set_instr(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();

      // ADD
      set_instr(0, 1, 0, 2'b00, 5'd5, 32'h0000_0010, 32'h1, 32'h4, 32'h9);
      push_exp(1, 5'd5, 32'h0000_0010);
      run_instr(-1, 32'h0);
      chk("add_stalls", stalls, 0);
      chk("add_req", 32'(saw_req), 0);
      check_wb("add");

      // LUI with resultSrc=01 and a non-word-aligned ALU value: not an access
      set_instr(0, 1, 1, 2'b01, 5'd3, 32'h0000_0055, 0, 0, 32'h1234_5000);
      push_exp(1, 5'd3, 32'h1234_5000);
      run_instr(-1, 32'hFFFF_FFFF);
      chk("lui_stalls", stalls, 0);
      chk("lui_req", 32'(saw_req), 0);
      chk("lui_err", 32'(memErr), 0);
      check_wb("lui");

      // JAL-style link value
      set_instr(0, 1, 0, 2'b10, 5'd1, 32'h0000_3000, 0, 32'h0000_2004, 0);
      push_exp(1, 5'd1, 32'h0000_2004);
      run_instr(-1, 32'h0);
      check_wb("pc4");

      // resultSrc=11 behaves as ALU
      set_instr(0, 1, 0, 2'b11, 5'd9, 32'h0000_0077, 0, 32'h0000_5555, 0);
      push_exp(1, 5'd9, 32'h0000_0077);
      run_instr(-1, 32'h0);
      chk("src11_stalls", stalls, 0);
      check_wb("src11");

      // SW, ready in first BUSY cycle; regWriteM set to show it is suppressed
      set_instr(1, 1, 0, 2'b00, 5'd4, 32'h0000_0204, 32'h1234_5678, 0, 0);
      push_exp(0, 5'd4, 32'h0);
      run_instr(0, 32'h0);
      chk("sw_stalls", stalls, 1);
      chk("sw_busy", busy, 1);
      chk("sw_memWe", 32'(last_we), 1);
      chk("sw_memWData", last_wd, 32'h1234_5678);
      chk("sw_addr", 32'(addr_ok), 1);
      chk("sw_req_drop", 32'(memReq), 0);
      check_wb("sw");

      // LW with ready 3 cycles after request
      set_instr(0, 1, 0, 2'b01, 5'd7, 32'h0000_0100, 0, 0, 0);
      push_exp(1, 5'd7, 32'hDEAD_BEEF);
      run_instr(3, 32'hDEAD_BEEF);
      chk("lw_stalls", stalls, 4);
      chk("lw_addr_stable", 32'(addr_ok), 1);
      chk("lw_memWe", 32'(last_we), 0);
      chk("lw_req_drop", 32'(memReq), 0);
      check_wb("lw");

      // back-to-back load: request is re-issued only after an idle cycle
      set_instr(0, 1, 0, 2'b01, 5'd8, 32'h0000_0108, 0, 0, 0);
      push_exp(1, 5'd8, 32'hCAFE_0001);
      run_instr(0, 32'hCAFE_0001);
      chk("b2b_stalls", stalls, 1);
      check_wb("b2b");

      // ready arriving exactly on the timeout cycle wins
      set_instr(0, 1, 0, 2'b01, 5'd10, 32'h0000_0040, 0, 0, 0);
      push_exp(1, 5'd10, 32'hA5A5_0F0F);
      run_instr(TO - 1, 32'hA5A5_0F0F);
      chk("lastrdy_stalls", stalls, TO);
      chk("lastrdy_busy", busy, TO);
      chk("lastrdy_err", 32'(memErr), 0);
      check_wb("lastrdy");

      // misaligned load
      set_instr(0, 1, 0, 2'b01, 5'd11, 32'h0000_0102, 0, 0, 0);
      push_exp(0, 5'd11, 32'h0);
      run_instr(-1, 32'h0);
      chk("mis_stalls", stalls, 0);
      chk("mis_req", 32'(saw_req), 0);
      chk("mis_req_after", 32'(memReq), 0);
      chk("mis_err", 32'(memErr), 1);
      check_wb("mis");

      // reset clears the sticky error
      set_instr(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("err_cleared", 32'(memErr), 0);

      // timeout: no ready at all
      set_instr(0, 1, 0, 2'b01, 5'd12, 32'h0000_0080, 0, 0, 0);
      push_exp(0, 5'd12, 32'h0);
      run_instr(-1, 32'h0);
      chk("to_stalls", stalls, TO);
      chk("to_busy", busy, TO);
      chk("to_req_drop", 32'(memReq), 0);
      chk("to_err", 32'(memErr), 1);
      check_wb("to");

      rst = 1'b1;
      tick();
      rst = 1'b0;

      // reset while BUSY drops the access
      set_instr(0, 1, 0, 2'b01, 5'd13, 32'h0000_0300, 32'h0000_00AA, 0, 0);
      memReady = 1'b0;
      tick();
      chk("midrst_req", 32'(memReq), 1);
      chk("midrst_addr", memAddr, 32'h0000_0300);
      tick();
      chk("midrst_stall", 32'(stallM), 1);
      rst = 1'b1;
      #1;
      chk("midrst_stall_forced", 32'(stallM), 0);
      tick();
      chk("midrst_req_after", 32'(memReq), 0);
      chk("midrst_we_after", 32'(memWe), 0);
      chk("midrst_addr_after", memAddr, 0);
      chk("midrst_regWriteW", 32'(regWriteW), 0);
      chk("midrst_RdW", 32'(RdW), 0);
      chk("midrst_resultW", resultW, 0);
      chk("midrst_err", 32'(memErr), 0);
      rst = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the five-stage RISC-V pipeline, directly downstream of the EX/MEM pipeline register. It turns loads and stores into a req/ready handshake on the data-memory port and stalls the pipeline while the access is outstanding. It selects the writeback result and registers it into the MEM/WB state consumed by the register file. Word accesses only; misaligned addresses and memory timeouts abort the access and are flagged.

## Interface
- TIMEOUT_CYCLES, 16: maximum BUSY cycles without memReady before the access is aborted (≥2).
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- memWriteM  in  1  store in MEM stage
- regWriteM  in  1  instruction writes Rd
- luiM  in  1  result is extImmM, overrides resultSrcM
- resultSrcM  in  2  00 ALU, 01 load data, 10 PC+4; 11 treated as ALU
- RdM  in  5  destination register
- ALUResultM  in  32  memory address / ALU result
- writeDataM  in  32  store data
- PCPlus4M  in  32  link value
- extImmM  in  32  upper immediate for LUI
- memReq  out  1  registered request, held until accepted
- memWe  out  1  registered, 1 = store
- memAddr  out  32  registered word address
- memWData  out  32  registered store data
- memReady  in  1  memory completes the access this cycle
- memRData  in  32  load data, valid when memReady=1
- stallM  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM
- regWriteW  out  1  MEM/WB write enable
- RdW  out  5  MEM/WB destination
- resultW  out  32  MEM/WB writeback value
- memErr  out  1  sticky error flag, cleared only by rst

## Operation
- access = memWriteM | (resultSrcM==01 & ~luiM); misaligned = access & ALUResultM[1:0]!=0.
- FSM states IDLE, BUSY.
- IDLE, no access: stallM=0; on the next edge MEM/WB captures regWriteM, RdM, and the selected result.
- Result priority: luiM→extImmM; 10→PCPlus4M; else ALUResultM.
- IDLE, misaligned: no request, stallM=0. Next edge: memErr←1 and regWriteW←0 (the instruction retires as a bubble).
- IDLE, aligned access: stallM=1. Next edge: →BUSY; memReq←1; memWe/memAddr/memWData←memWriteM/ALUResultM/writeDataM; timeout counter←0; MEM/WB gets a bubble (regWriteW=0).
- BUSY, memReady=0: stallM=1, counter increments, request outputs held stable, MEM/WB bubble.
- BUSY, memReady=1: stallM=0. Next edge: →IDLE; memReq←0.
  - Load: resultW←memRData, regWriteW←regWriteM.
  - Store: regWriteW←0.
- BUSY, counter==TIMEOUT_CYCLES-1 and memReady=0: treated as a completion with abort. stallM=0. Next edge: →IDLE, memReq←0, memErr←1, regWriteW←0.
- memReady=1 on the timeout cycle: ready wins and there is no error.
- memReady while in IDLE is ignored.

## Timing
- Reset values: memReq, memWe, regWriteW, memErr = 0; memAddr, memWData, resultW = 0; RdW = 0; FSM IDLE; counter 0. stallM is forced to 0 while rst=1.
- rst mid-access (BUSY): next edge returns to IDLE with memReq=0 and the access is dropped. The memory must tolerate a withdrawn request.
- Non-memory instruction: 1-cycle latency, EX/MEM→MEM/WB.
- Memory instruction whose ready arrives in the first BUSY cycle: 2 cycles in stage, 1 stall cycle.
- Each additional wait cycle adds 1 stall cycle.
- Worst case: TIMEOUT_CYCLES+1 cycles.
- Back-to-back accesses: after completion the FSM is in IDLE with the new EX/MEM contents. The next request is issued one cycle later, so memReq drops for at least 1 cycle between accesses.

## Structure
- Shared package pipe_pkg holds:
  - resultSrc encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10;
  - FSM state type (IDLE, BUSY);
  - widths XLEN=32 and REG_AW=5.
- One sub-module, mem_wb_reg: the MEM/WB register with synchronous reset, a bubble input and the result-select mux.
- The FSM, timeout counter and request registers stay in the top module.

## Test plan
- ADD, regWriteM=1, RdM=5, ALUResultM=0x0000_0010, resultSrcM=00 → next edge regWriteW=1, RdW=5, resultW=0x10, stallM=0 throughout.
- LW, addr 0x100, memReady raised 3 cycles after memReq, memRData=0xDEAD_BEEF, RdM=7 → stallM high for 4 cycles, memAddr=0x100 stable while memReq=1, then resultW=0xDEAD_BEEF, RdW=7, regWriteW=1.
- SW, addr 0x204, writeDataM=0x1234_5678, memReady in the first BUSY cycle → memWe=1, memWData=0x1234_5678, 1 stall cycle, regWriteW=0.
- LW to 0x102 → memReq never asserted, stallM=0, memErr=1 after 1 edge, regWriteW=0.
- LW with memReady held 0 → exactly TIMEOUT_CYCLES BUSY cycles, memReq drops, memErr=1, regWriteW=0.
- Variant: memReady=1 exactly on the timeout cycle → normal completion, memErr stays 0.
- LUI (luiM=1, extImmM=0x1234_5000, resultSrcM=01) → no memory access, resultW=0x1234_5000.
- rst asserted mid-BUSY → next edge memReq=0, all outputs at their reset values.
